shift_normalizer: RTL and testbench

SHIFT_NORMALIZER -- requirements
Module: shift_normalizer

---
 rtl/shift_normalizer.sv | 156 +++++++++++++++
 tb/tb_shift_normalizer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/shift_normalizer.sv
// rtl/shift_normalizer.sv - add-then-normalize unit: controller FSM plus datapath (optional SHIFT_COUNT_EN shift counter)

module shift_normalizer_ctrl (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic i_r_msb,
  input  logic i_r_zero,
  output logic L,
  output logic S,
  output logic done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A zero sum has no leading one to find, so it exits SHIFT like a normalized value.
  always_comb begin
    w_next = r_state;
    L      = 1'b0;
    S      = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = LOAD;
      end
      LOAD: begin
        L      = 1'b1;
        w_next = SHIFT;
      end
      SHIFT: begin
        if (i_r_msb || i_r_zero) begin
          w_next = DONE;
        end else begin
          S = 1'b1;
        end
      end
      DONE: begin
        done = 1'b1;
        if (!start) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

module shift_normalizer_dp (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic       i_shift,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] R,
  output logic       o_r_msb,
  output logic       o_r_zero
);

  logic [7:0] r_r;
  logic [7:0] w_sum;

  // Carry out of the add is dropped by the 8-bit target width.
  assign w_sum = A + B;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_r <= 8'h00;
    end else if (i_load) begin
      r_r <= w_sum;
    end else if (i_shift) begin
      r_r <= {r_r[6:0], 1'b0};
    end
  end

  assign R        = r_r;
  assign o_r_msb  = r_r[7];
  assign o_r_zero = (r_r == 8'h00);

endmodule

module shift_normalizer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] R,
  output logic       L,
  output logic       S,
  output logic       done
`ifdef SHIFT_COUNT_EN
  ,
  output logic [2:0] cnt
`endif
);

  logic w_r_msb;
  logic w_r_zero;

  shift_normalizer_ctrl u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .i_r_msb  (w_r_msb),
    .i_r_zero (w_r_zero),
    .L        (L),
    .S        (S),
    .done     (done)
  );

  shift_normalizer_dp u_dp (
    .clk      (clk),
    .reset    (reset),
    .i_load   (L),
    .i_shift  (S),
    .A        (A),
    .B        (B),
    .R        (R),
    .o_r_msb  (w_r_msb),
    .o_r_zero (w_r_zero)
  );

`ifdef SHIFT_COUNT_EN
  logic [2:0] r_cnt;

  // At most seven shifts can occur, so the 3-bit counter never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 3'd0;
    end else if (L) begin
      r_cnt <= 3'd0;
    end else if (S) begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

  assign cnt = r_cnt;
`endif

endmodule

// File: tb/tb_shift_normalizer.sv
// tb/tb_shift_normalizer.sv - randomized self-checking bench for shift_normalizer against an arithmetic model

module tb_shift_normalizer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] R;
  logic       L;
  logic       S;
  logic       done;
`ifdef SHIFT_COUNT_EN
  logic [2:0] cnt;
`endif

  int n_checks;
  int n_fail;

  shift_normalizer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .R     (R),
    .L     (L),
    .S     (S),
    .done  (done)
`ifdef SHIFT_COUNT_EN
    ,
    .cnt   (cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, got running, need finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: leading-zero count of the wrapped sum and the left-justified value.
  function automatic int model_k(input int a, input int b);
    int s;
    int k;
    s = (a + b) % 256;
    k = 0;
    if (s == 0) return 0;
    while (s < 128) begin
      s = s * 2;
      k++;
    end
    return k;
  endfunction

  function automatic int model_r(input int a, input int b);
    int s;
    s = (a + b) % 256;
    return (s * (1 << model_k(a, b))) % 256;
  endfunction

  task automatic run_op(input int a, input int b, input int hold);
    int k;
    int exp_r;
    int cyc;
    int ns;
    int nl;
    int overlap;
    k     = model_k(a, b);
    exp_r = model_r(a, b);
    A     = a[7:0];
    B     = b[7:0];
    start = 1'b1;
    @(negedge clk);
    check("load_strobe", {31'd0, L}, 32'd1);
    check("load_no_shift", {31'd0, S}, 32'd0);
    cyc = 0; ns = 0; nl = 0; overlap = 0;
    while (1) begin
      @(negedge clk);
      if (L && S) overlap++;
      if (done) break;
      if (S) ns++;
      if (L) nl++;
      cyc++;
      A = $urandom;
      B = $urandom;
      if (cyc > 20) break;
    end
    check("latency", cyc, k + 1);
    check("shift_count", ns, k);
    check("extra_load", nl, 0);
    check("l_s_overlap", overlap, 0);
    check("done_high", {31'd0, done}, 32'd1);
    check("result", {24'd0, R}, exp_r);
`ifdef SHIFT_COUNT_EN
    check("cnt", {29'd0, cnt}, k);
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("done_hold", {31'd0, done}, 32'd1);
      check("result_hold", {24'd0, R}, exp_r);
    end
    start = 1'b0;
    @(negedge clk);
    check("idle_done_low", {31'd0, done}, 32'd0);
    check("idle_r_held", {24'd0, R}, exp_r);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b1;
    A        = 8'd3;
    B        = 8'd8;
    @(negedge clk);
    check("rst_R", {24'd0, R}, 32'd0);
    check("rst_L", {31'd0, L}, 32'd0);
    check("rst_S", {31'd0, S}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    run_op(3, 8, 2);
    run_op(8, 4, 3);
    run_op(8'h80, 8'h00, 0);
    run_op(8'hFF, 8'h01, 1);
    run_op(1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      run_op($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Asynchronous reset in the middle of a seven-shift run.
    A = 8'd1;
    B = 8'd0;
    start = 1'b1;
    repeat (4) @(negedge clk);
    check("pre_reset_shift", {31'd0, S}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_R", {24'd0, R}, 32'd0);
    check("async_L", {31'd0, L}, 32'd0);
    check("async_S", {31'd0, S}, 32'd0);
    check("async_done", {31'd0, done}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post_reset_idle_L", {31'd0, L}, 32'd0);
      check("post_reset_idle_done", {31'd0, done}, 32'd0);
    end
    run_op(8'h10, 8'h05, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
